wb_scoreboard: RTL and testbench

Write-back scheduler and hazard scoreboard for the register file. Shares the single register-file write port between the ALU write-back path and the load/memory write-back path with round-robin arbitration. Tracks which destination registers have writes in flight and stalls decode on RAW and WAW hazards. Sits between decode/issue, the two execution write-back sources, and the `reg_file` write port (`mem_op`, `rd`, `write_data`).

---
 rtl/wb_scoreboard.sv | 124 ++++++++++++
 tb/tb_wb_scoreboard.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_scoreboard.sv
// Write-back scheduler and RAW/WAW hazard scoreboard in front of the register file.
// ALU and MEM write-backs share the single registered write port under round-robin arbitration.
//
// last_grant | meaning
// SRC_ALU    | ALU won the most recent grant; MEM wins the next tie
// SRC_MEM    | MEM won the most recent grant; ALU wins the next tie
module wb_scoreboard #(
   parameter int NUM_SRC = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        issue_valid,
   input  logic        issue_wr,
   input  logic [4:0]  issue_rs1,
   input  logic [4:0]  issue_rs2,
   input  logic [4:0]  issue_rd,
   output logic        issue_stall,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   output logic        alu_ready,
   input  logic        mem_valid,
   input  logic [4:0]  mem_rd,
   input  logic [31:0] mem_data,
   output logic        mem_ready,
   output logic        rf_op,
   output logic [4:0]  rf_rd,
   output logic [31:0] rf_write_data,
   output logic [31:0] busy_mask,
   output logic        wb_error
);

   localparam int SRC_W = $clog2(NUM_SRC);
   localparam logic [SRC_W-1:0] SRC_ALU = SRC_W'(0);
   localparam logic [SRC_W-1:0] SRC_MEM = SRC_W'(1);

   localparam logic READ_REG_DATA  = 1'b0;
   localparam logic WRITE_REG_DATA = 1'b1;

   logic [31:1]      busy_q, busy_d;
   logic [31:0]      busy_full;
   logic [SRC_W-1:0] last_grant_q, last_grant_d;
   logic             rf_op_q, rf_op_d;
   logic [4:0]       rf_rd_q, rf_rd_d;
   logic [31:0]      rf_data_q, rf_data_d;
   logic             wb_error_q, wb_error_d;

   logic             xfer;
   logic             set_en;
   logic [4:0]       xfer_rd;
   logic [31:0]      xfer_data;

   assign busy_full = {busy_q, 1'b0};

   assign issue_stall = issue_valid & (busy_full[issue_rs1] | busy_full[issue_rs2]
                                       | (issue_wr & busy_full[issue_rd]));

   assign set_en = issue_valid & ~issue_stall & issue_wr & (issue_rd != 5'd0);

   assign alu_ready = alu_valid & (~mem_valid | (last_grant_q == SRC_MEM));
   assign mem_ready = mem_valid & (~alu_valid | (last_grant_q == SRC_ALU));

   assign xfer      = alu_ready | mem_ready;
   assign xfer_rd   = mem_ready ? mem_rd   : alu_rd;
   assign xfer_data = mem_ready ? mem_data : alu_data;

   // Clear lands on the edge where reg_file commits the write; a same-cycle set overrides it.
   always_comb begin
      busy_d = busy_q;
      for (int i = 1; i < 32; i++) begin
         if ((rf_op_q == WRITE_REG_DATA) && (rf_rd_q == 5'(i))) begin
            busy_d[i] = 1'b0;
         end
         if (set_en && (issue_rd == 5'(i))) begin
            busy_d[i] = 1'b1;
         end
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      rf_op_d      = READ_REG_DATA;
      rf_rd_d      = rf_rd_q;
      rf_data_d    = rf_data_q;
      wb_error_d   = wb_error_q;
      if (xfer) begin
         last_grant_d = mem_ready ? SRC_MEM : SRC_ALU;
         rf_rd_d      = xfer_rd;
         rf_data_d    = xfer_data;
         // r0 is accepted but never written and never tracked.
         if (xfer_rd != 5'd0) begin
            rf_op_d = WRITE_REG_DATA;
            if (!busy_full[xfer_rd]) begin
               wb_error_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         busy_q       <= '0;
         last_grant_q <= SRC_MEM;
         rf_op_q      <= READ_REG_DATA;
         rf_rd_q      <= 5'd0;
         rf_data_q    <= 32'd0;
         wb_error_q   <= 1'b0;
      end else begin
         busy_q       <= busy_d;
         last_grant_q <= last_grant_d;
         rf_op_q      <= rf_op_d;
         rf_rd_q      <= rf_rd_d;
         rf_data_q    <= rf_data_d;
         wb_error_q   <= wb_error_d;
      end
   end

   assign rf_op         = rf_op_q;
   assign rf_rd         = rf_rd_q;
   assign rf_write_data = rf_data_q;
   assign busy_mask     = busy_full;
   assign wb_error      = wb_error_q;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Self-checking bench for wb_scoreboard: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural scoreboard/arbiter model.
module tb_wb_scoreboard;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        issue_valid, issue_wr;
   logic [4:0]  issue_rs1, issue_rs2, issue_rd;
   logic        issue_stall;
   logic        alu_valid, mem_valid;
   logic [4:0]  alu_rd, mem_rd;
   logic [31:0] alu_data, mem_data;
   logic        alu_ready, mem_ready;
   logic        rf_op;
   logic [4:0]  rf_rd;
   logic [31:0] rf_write_data;
   logic [31:0] busy_mask;
   logic        wb_error;

   always #5 clock = ~clock;

   wb_scoreboard #(.NUM_SRC(2)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .issue_valid   (issue_valid),
      .issue_wr      (issue_wr),
      .issue_rs1     (issue_rs1),
      .issue_rs2     (issue_rs2),
      .issue_rd      (issue_rd),
      .issue_stall   (issue_stall),
      .alu_valid     (alu_valid),
      .alu_rd        (alu_rd),
      .alu_data      (alu_data),
      .alu_ready     (alu_ready),
      .mem_valid     (mem_valid),
      .mem_rd        (mem_rd),
      .mem_data      (mem_data),
      .mem_ready     (mem_ready),
      .rf_op         (rf_op),
      .rf_rd         (rf_rd),
      .rf_write_data (rf_write_data),
      .busy_mask     (busy_mask),
      .wb_error      (wb_error)
   );

   int n_vec = 0;
   int n_bad = 0;

   // reference model: pending-write set, last winner, one-deep output stage
   bit [31:0] m_busy;
   bit        m_last_mem;
   bit        m_pend;
   bit [4:0]  m_rd;
   bit [31:0] m_data;
   bit        m_err;
   bit        alu_acc, mem_acc;

   logic        obs_stall, obs_alu_rdy, obs_mem_rdy, obs_rf_op, obs_err;
   logic [4:0]  obs_rf_rd;
   logic [31:0] obs_rf_data, obs_busy;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      issue_valid = 1'b0; issue_wr = 1'b0;
      issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_rd = 5'd0;
      alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
      mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
   endtask

   task automatic model_reset();
      m_busy = '0; m_last_mem = 1'b1; m_pend = 1'b0;
      m_rd = '0; m_data = '0; m_err = 1'b0;
      alu_acc = 1'b0; mem_acc = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clock);
      @(negedge clock);
      check_val("rst_busy",    busy_mask, 32'd0);
      check_val("rst_rf_op",   32'(rf_op), 32'd0);
      check_val("rst_rf_rd",   32'(rf_rd), 32'd0);
      check_val("rst_rf_data", rf_write_data, 32'd0);
      check_val("rst_err",     32'(wb_error), 32'd0);
      check_val("rst_alu_rdy", 32'(alu_ready), 32'd0);
      check_val("rst_mem_rdy", 32'(mem_ready), 32'd0);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
   endtask

   // One clock: check every output mid-cycle, then advance the model at the edge.
   task automatic cycle();
      bit        e_stall, e_alu, e_mem;
      bit [31:0] nb;
      bit [4:0]  xr;
      bit [31:0] xd;
      @(negedge clock);
      e_stall = issue_valid && (m_busy[issue_rs1] || m_busy[issue_rs2] ||
                                (issue_wr && m_busy[issue_rd]));
      e_alu   = alu_valid && (!mem_valid || m_last_mem);
      e_mem   = mem_valid && (!alu_valid || !m_last_mem);
      obs_stall = issue_stall; obs_alu_rdy = alu_ready; obs_mem_rdy = mem_ready;
      obs_rf_op = rf_op; obs_rf_rd = rf_rd; obs_rf_data = rf_write_data;
      obs_busy = busy_mask; obs_err = wb_error;
      check_val("issue_stall",   32'(obs_stall),   32'(e_stall));
      check_val("alu_ready",     32'(obs_alu_rdy), 32'(e_alu));
      check_val("mem_ready",     32'(obs_mem_rdy), 32'(e_mem));
      check_val("rf_op",         32'(obs_rf_op),   32'(m_pend));
      check_val("rf_rd",         32'(obs_rf_rd),   32'(m_rd));
      check_val("rf_write_data", obs_rf_data,      m_data);
      check_val("busy_mask",     obs_busy,         m_busy);
      check_val("wb_error",      32'(obs_err),     32'(m_err));
      @(posedge clock);
      nb = m_busy;
      if (m_pend) nb[m_rd] = 1'b0;
      if (issue_valid && !e_stall && issue_wr && issue_rd != 5'd0) nb[issue_rd] = 1'b1;
      alu_acc = e_alu;
      mem_acc = e_mem;
      if (e_alu || e_mem) begin
         xr = e_mem ? mem_rd : alu_rd;
         xd = e_mem ? mem_data : alu_data;
         if (xr != 5'd0 && !m_busy[xr]) m_err = 1'b1;
         m_pend = (xr != 5'd0);
         m_rd = xr;
         m_data = xd;
         m_last_mem = e_mem;
      end else begin
         m_pend = 1'b0;
      end
      m_busy = nb;
      #1;
   endtask

   function automatic logic [4:0] pick_rd();
      logic [4:0] r;
      for (int t = 0; t < 8; t++) begin
         r = 5'($urandom_range(1, 31));
         if (m_busy[r]) return r;
      end
      return 5'($urandom_range(0, 31));
   endfunction

   initial begin
      clear_inputs();
      reset_n = 1'b0;
      model_reset();
      do_reset();
      cycle();
      cycle();

      // RAW on r5, released by an ALU write-back
      issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd5;
      cycle();
      issue_wr = 1'b0; issue_rd = 5'd0; issue_rs1 = 5'd5;
      cycle();
      check_val("raw_stall", 32'(obs_stall), 32'd1);
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      cycle();
      check_val("raw_alu_ready", 32'(obs_alu_rdy), 32'd1);
      alu_valid = 1'b0;
      cycle();
      check_val("raw_rf_op",   32'(obs_rf_op), 32'd1);
      check_val("raw_rf_rd",   32'(obs_rf_rd), 32'd5);
      check_val("raw_rf_data", obs_rf_data, 32'hDEADBEEF);
      check_val("raw_stall_n1", 32'(obs_stall), 32'd1);
      cycle();
      check_val("raw_release", 32'(obs_stall), 32'd0);
      check_val("raw_busy5",   32'(obs_busy[5]), 32'd0);
      clear_inputs();

      // contention: fresh reset so ALU wins the first tie
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'(k);
         cycle();
      end
      clear_inputs();
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h0000_1111;
      mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h0000_2222;
      for (int k = 0; k < 4; k++) begin
         cycle();
         check_val("cont_alu_grant", 32'(obs_alu_rdy), 32'((k % 2) == 0));
         check_val("cont_mem_grant", 32'(obs_mem_rdy), 32'((k % 2) == 1));
         if (k > 0) begin
            check_val("cont_rf_op", 32'(obs_rf_op), 32'd1);
            check_val("cont_rf_rd", 32'(obs_rf_rd), 32'(k));
         end
         if (alu_acc) begin
            if (alu_rd == 5'd1) begin alu_rd = 5'd3; alu_data = 32'h0000_3333; end
            else alu_valid = 1'b0;
         end
         if (mem_acc) begin
            if (mem_rd == 5'd2) begin mem_rd = 5'd4; mem_data = 32'h0000_4444; end
            else mem_valid = 1'b0;
         end
      end
      cycle();
      check_val("cont_last_op", 32'(obs_rf_op), 32'd1);
      check_val("cont_last_rd", 32'(obs_rf_rd), 32'd4);
      cycle();
      check_val("cont_busy_clear", obs_busy, 32'd0);

      // WAW on r7, then r0 as destination and as write-back target
      issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd7;
      cycle();
      cycle();
      check_val("waw_stall", 32'(obs_stall), 32'd1);
      issue_rd = 5'd0; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
      cycle();
      check_val("rd0_no_stall", 32'(obs_stall), 32'd0);
      issue_valid = 1'b0; issue_wr = 1'b0;
      cycle();
      check_val("rd0_busy", obs_busy, 32'h0000_0080);
      mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h0000_CAFE;
      cycle();
      check_val("mem_rd0_ready", 32'(obs_mem_rdy), 32'd1);
      mem_valid = 1'b0;
      cycle();
      check_val("mem_rd0_rf_op", 32'(obs_rf_op), 32'd0);
      check_val("mem_rd0_busy",  obs_busy, 32'h0000_0080);
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0000_0007;
      cycle();
      alu_valid = 1'b0;
      cycle();
      cycle();
      check_val("waw_busy_clear", obs_busy, 32'd0);

      // protocol error: write-back to an idle register
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_0099;
      cycle();
      alu_valid = 1'b0;
      cycle();
      check_val("err_rf_op", 32'(obs_rf_op), 32'd1);
      check_val("err_rf_rd", 32'(obs_rf_rd), 32'd9);
      check_val("err_flag",  32'(obs_err), 32'd1);
      repeat (3) begin
         cycle();
         check_val("err_sticky", 32'(obs_err), 32'd1);
      end

      // asynchronous reset while a write is in the output stage
      do_reset();
      issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd12;
      cycle();
      clear_inputs();
      alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h1234_5678;
      cycle();
      alu_valid = 1'b0;
      #1;
      check_val("pre_rst_rf_op", 32'(rf_op), 32'd1);
      reset_n = 1'b0;
      #1;
      check_val("async_rf_op", 32'(rf_op), 32'd0);
      check_val("async_busy",  busy_mask, 32'd0);
      check_val("async_rf_rd", 32'(rf_rd), 32'd0);
      model_reset();
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      cycle();
      cycle();

      // randomized traffic; requesters hold until accepted
      do_reset();
      for (int c = 0; c < 400; c++) begin
         issue_valid = 1'($urandom_range(0, 1));
         issue_wr    = ($urandom_range(0, 9) < 6);
         issue_rs1   = 5'($urandom_range(0, 31));
         issue_rs2   = 5'($urandom_range(0, 31));
         issue_rd    = 5'($urandom_range(0, 31));
         if (!alu_valid || alu_acc) begin
            alu_valid = ($urandom_range(0, 3) != 0);
            alu_rd    = pick_rd();
            alu_data  = $urandom;
         end
         if (!mem_valid || mem_acc) begin
            mem_valid = ($urandom_range(0, 3) != 0);
            mem_rd    = pick_rd();
            mem_data  = $urandom;
         end
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
